// File: rtl/lwc_arb_pkg.sv
// Shared types and the rotate-priority search used by the LWC register write arbiter.
package lwc_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int MAX_NREQ = 8;

    // Returns {found, idx}. Searches from last+1 and wraps. Unused upper valid bits
    // must be zero, which makes the mod-8 walk equal to a mod-NREQ walk.
    function automatic logic [3:0] next_rr(input logic [MAX_NREQ-1:0] valid,
                                           input logic [2:0]          last);
        logic [2:0] idx;
        logic [2:0] sel;
        logic       found;
        found = 1'b0;
        sel   = '0;
        for (int i = 1; i <= MAX_NREQ; i++) begin
            idx = last + 3'(i);
            if (!found && valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        return {found, sel};
    endfunction

endpackage

// File: rtl/lwc_rr_pick.sv
// Combinational rotate-priority encoder: picks the first valid requester after last.
module lwc_rr_pick
    import lwc_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [MAX_NREQ-1:0] valid_pad;
    logic [3:0]          res;

    always_comb begin
        valid_pad             = '0;
        valid_pad[NREQ-1:0]   = valid;
        res                   = next_rr(valid_pad, 3'(last));
        found                 = res[3];
        idx                   = IDX_W'(res[2:0]);
    end

endmodule

// File: rtl/lwc_reg_write_arb.sv
// Round-robin write arbiter with locked bursts, feeding a shared enable-gated
// register through a registered d/en stage.
module lwc_reg_write_arb
    import lwc_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_lock,
    output logic [NREQ-1:0]       req_ready,
    output logic                  reg_en,
    output logic [WIDTH-1:0]      reg_d,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             reg_en_q;
    logic [WIDTH-1:0] reg_d_q;
    logic [IDX_W-1:0] grant_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] winner;
    logic             accept_any;
    logic [WIDTH-1:0] win_data;

    lwc_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .valid (req_valid),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        req_ready = '0;
        winner    = (state_q == LOCKED) ? owner_q : pick_idx;
        if (!rst) begin
            if (state_q == LOCKED)
                req_ready[owner_q] = req_valid[owner_q];
            else if (pick_found)
                req_ready[pick_idx] = 1'b1;
        end
        accept_any = |(req_valid & req_ready);
        win_data   = req_data[int'(winner)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        if (accept_any) begin
            owner_d = winner;
            last_d  = winner;
            // The lock bit of the accepted beat alone decides whether ownership persists.
            state_d = req_lock[winner] ? LOCKED : IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Output stage: data and index only load on an accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_en_q <= 1'b0;
            reg_d_q  <= '0;
            grant_q  <= '0;
        end else begin
            reg_en_q <= accept_any;
            if (accept_any) begin
                reg_d_q <= win_data;
                grant_q <= winner;
            end
        end
    end

    assign reg_en    = reg_en_q;
    assign reg_d     = reg_d_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == LOCKED);

endmodule
